// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain binary/Gray pointer, read-pointer synchroniser and registered full flag.
// Defining FIFO_WPTR_ALMOST_FULL_EN adds the registered almost_full output and its Gray-to-binary converter.
module fifo_wptr_full #(
   parameter int ADDRWIDTH   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_MARGIN   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [ADDRWIDTH:0]   rd_gray_async,
   output logic [ADDRWIDTH-1:0] wr_addr,
   output logic                 wr_accept,
   output logic [ADDRWIDTH:0]   wr_gray,
   output logic                 full,
   output logic                 wr_ovf
`ifdef FIFO_WPTR_ALMOST_FULL_EN
   ,
   output logic                 almost_full
`endif
);
   localparam int PW = ADDRWIDTH + 1;
   // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
   localparam logic [PW-1:0] TOP_INV = {PW{1'b1}} << (ADDRWIDTH - 1);
   logic [PW-1:0] wr_bin_q, wr_bin_d;
   logic [PW-1:0] wr_gray_q, wr_gray_d;
   logic [PW-1:0] rq_q [SYNC_STAGES];
   logic [PW-1:0] rq_d [SYNC_STAGES];
   logic          full_q, full_d;
   logic          wr_ovf_q, wr_ovf_d;
   always_comb begin
      wr_accept = wr_en & ~full_q;
      wr_bin_d  = wr_bin_q + PW'(wr_accept);
      wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
      rq_d[0]   = rd_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) rq_d[i] = rq_q[i-1];
      full_d    = wr_gray_d == (rq_q[SYNC_STAGES-1] ^ TOP_INV);
      wr_ovf_d  = wr_en & full_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bin_q  <= '0;
         wr_gray_q <= '0;
         rq_q      <= '{default: '0};
         full_q    <= 1'b0;
         wr_ovf_q  <= 1'b0;
      end else begin
         wr_bin_q  <= wr_bin_d;
         wr_gray_q <= wr_gray_d;
         rq_q      <= rq_d;
         full_q    <= full_d;
         wr_ovf_q  <= wr_ovf_d;
      end
   end
   assign wr_addr = wr_bin_q[ADDRWIDTH-1:0];
   assign wr_gray = wr_gray_q;
   assign full    = full_q;
   assign wr_ovf  = wr_ovf_q;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
   logic [PW-1:0] rd_bin_sync, used;
   logic          almost_full_q, almost_full_d;
   always_comb begin
      rd_bin_sync = '0;
      for (int i = 0; i < PW; i++) rd_bin_sync[i] = ^(rq_q[SYNC_STAGES-1] >> i);
      used          = wr_bin_d - rd_bin_sync;
      almost_full_d = used >= PW'(2**ADDRWIDTH - AF_MARGIN);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) almost_full_q <= 1'b0;
      else        almost_full_q <= almost_full_d;
   end
   assign almost_full = almost_full_q;
`endif
endmodule
